// File: rtl/gp_bias_pkg.sv
// Shared types and helpers for the streaming bias-add / requantise stage.
// Default widths, channel index width and signed saturation function.
package gp_bias_pkg;

    localparam int NUM_CH_D = 128;
    localparam int ACC_W_D  = 32;
    localparam int BIAS_W_D = 32;
    localparam int OUT_W_D  = 16;

    localparam int CH_W = $clog2(NUM_CH_D);

    typedef logic signed [ACC_W_D-1:0]  acc_t;
    typedef logic signed [BIAS_W_D-1:0] bias_t;
    typedef logic signed [OUT_W_D-1:0]  out_t;

    typedef struct packed {
        logic signed [63:0] val;
        logic               hi;
        logic               lo;
    } sat_t;

    // Clip a wide signed value to a signed range of 'width' bits.
    function automatic sat_t sat_signed(input logic signed [63:0] value,
                                        input int width);
        sat_t r;
        logic signed [63:0] mx;
        logic signed [63:0] mn;
        mx = (64'sd1 <<< (width - 1)) - 64'sd1;
        mn = -mx - 64'sd1;
        r.hi  = value > mx;
        r.lo  = value < mn;
        r.val = r.hi ? mx : (r.lo ? mn : value);
        return r;
    endfunction

endpackage

// File: rtl/bias_regfile.sv
// Runtime-loadable per-channel bias store: NUM_CH x BIAS_W flops.
// Ports: clk, rst_n, we/wr_addr/wr_data write port, rd_addr/rd_data comb read.
module bias_regfile
    import gp_bias_pkg::*;
#(
    parameter int NUM_CH = 128,
    parameter int BIAS_W = 32
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      we,
    input  logic [$clog2(NUM_CH)-1:0] wr_addr,
    input  logic [BIAS_W-1:0]         wr_data,
    input  logic [$clog2(NUM_CH)-1:0] rd_addr,
    output logic [BIAS_W-1:0]         rd_data
);

    localparam int AW = $clog2(NUM_CH);

    logic [BIAS_W-1:0] mem [NUM_CH];
    logic              addr_ok;

    // Addresses past the last channel are dropped.
    assign addr_ok = {{(32-AW){1'b0}}, wr_addr} < 32'(NUM_CH);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NUM_CH; i++) begin
                mem[i] <= '0;
            end
        end else if (we && addr_ok) begin
            mem[wr_addr] <= wr_data;
        end
    end

    assign rd_data = mem[rd_addr];

endmodule

// File: rtl/bias_add_stream.sv
// Streaming per-channel bias add, arithmetic shift and saturate to OUT_W.
// Ports: cfg_* bias load, ch_clear, in_* / out_* valid-ready stream, sat_flag.
// Optional macro BIAS_RELU_EN: fused ReLU, sat_flag then marks upper clip only.
module bias_add_stream
    import gp_bias_pkg::*;
#(
    parameter int NUM_CH = 128,
    parameter int ACC_W  = 32,
    parameter int BIAS_W = 32,
    parameter int OUT_W  = 16,
    parameter int SHIFT  = 0
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      cfg_we,
    input  logic [$clog2(NUM_CH)-1:0] cfg_addr,
    input  logic [BIAS_W-1:0]         cfg_data,
    input  logic                      ch_clear,
    input  logic                      in_valid,
    output logic                      in_ready,
    input  logic [ACC_W-1:0]          in_data,
    output logic                      out_valid,
    input  logic                      out_ready,
    output logic [OUT_W-1:0]          out_data,
    output logic [$clog2(NUM_CH)-1:0] out_ch,
    output logic                      out_last,
    output logic                      sat_flag
);

    localparam int CHW = $clog2(NUM_CH);
    localparam logic [CHW-1:0] CH_MAX = CHW'(NUM_CH - 1);

    logic                    accept;
    logic [CHW-1:0]          ch_q;
    logic [CHW-1:0]          ch_inc;
    logic [BIAS_W-1:0]       bias_rd;
    logic signed [ACC_W:0]   sum;
    logic signed [ACC_W:0]   shifted;
    logic signed [63:0]      wide;
    sat_t                    sat;
    logic [OUT_W-1:0]        res;
    logic                    res_sat;
    logic                    sat_unused;

    assign in_ready = !out_valid | out_ready;
    assign accept   = in_valid & in_ready;

    // Read happens before any same-edge write, so a colliding beat
    // sees the old bias.
    bias_regfile #(
        .NUM_CH (NUM_CH),
        .BIAS_W (BIAS_W)
    ) u_regfile (
        .clk     (clk),
        .rst_n   (rst_n),
        .we      (cfg_we),
        .wr_addr (cfg_addr),
        .wr_data (cfg_data),
        .rd_addr (ch_q),
        .rd_data (bias_rd)
    );

    always_comb begin
        sum = $signed({in_data[ACC_W-1], in_data})
            + $signed({{(ACC_W+1-BIAS_W){bias_rd[BIAS_W-1]}}, bias_rd});
        shifted = sum >>> SHIFT;
        wide    = {{(63-ACC_W){shifted[ACC_W]}}, shifted};
        sat     = sat_signed(wide, OUT_W);
`ifdef BIAS_RELU_EN
        res        = sat.val[63] ? '0 : sat.val[OUT_W-1:0];
        res_sat    = sat.hi;
        sat_unused = ^{sat.val[62:OUT_W], sat.lo};
`else
        res        = sat.val[OUT_W-1:0];
        res_sat    = sat.hi | sat.lo;
        sat_unused = ^sat.val[63:OUT_W];
`endif
    end

    assign ch_inc = (ch_q == CH_MAX) ? '0 : ch_q + 1'b1;

    // ch_clear wins over the increment; the accepted beat still
    // used the pre-clear channel.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ch_q <= '0;
        end else if (ch_clear) begin
            ch_q <= '0;
        end else if (accept) begin
            ch_q <= ch_inc;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid <= 1'b0;
            out_data  <= '0;
            out_ch    <= '0;
            out_last  <= 1'b0;
            sat_flag  <= 1'b0;
        end else if (accept) begin
            out_valid <= 1'b1;
            out_data  <= res;
            out_ch    <= ch_q;
            out_last  <= (ch_q == CH_MAX);
            sat_flag  <= res_sat;
        end else if (out_ready) begin
            out_valid <= 1'b0;
        end
    end

endmodule

// File: tb/tb_bias_add_stream.sv
// Directed self-checking bench for bias_add_stream (NUM_CH=4, OUT_W=16).
// Table-driven streaming vectors plus stall, collision, reset, clear cases.
module tb_bias_add_stream;

    localparam int NUM_CH = 4;
    localparam int ACC_W  = 32;
    localparam int BIAS_W = 32;
    localparam int OUT_W  = 16;
    localparam int CHW    = 2;

    logic              clk;
    logic              rst_n;
    logic              cfg_we;
    logic [CHW-1:0]    cfg_addr;
    logic [BIAS_W-1:0] cfg_data;
    logic              ch_clear;
    logic              in_valid;
    logic              in_ready;
    logic [ACC_W-1:0]  in_data;
    logic              out_valid;
    logic              out_ready;
    logic [OUT_W-1:0]  out_data;
    logic [CHW-1:0]    out_ch;
    logic              out_last;
    logic              sat_flag;

    int tests;
    int fails;

    bias_add_stream #(
        .NUM_CH (NUM_CH),
        .ACC_W  (ACC_W),
        .BIAS_W (BIAS_W),
        .OUT_W  (OUT_W),
        .SHIFT  (0)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .cfg_we    (cfg_we),
        .cfg_addr  (cfg_addr),
        .cfg_data  (cfg_data),
        .ch_clear  (ch_clear),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_ch    (out_ch),
        .out_last  (out_last),
        .sat_flag  (sat_flag)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        int acc;
        int exp_data;
        int exp_relu;
        int exp_ch;
        bit exp_last;
        bit exp_sat;
        bit exp_sat_relu;
    } vec_t;

    vec_t vecs [9];

    task automatic chk(input string nm, input longint got, input longint exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s: got %0d expected %0d", nm, got, exp);
        end
    endtask

    task automatic write_bias(input int addr, input int data);
        @(negedge clk);
        cfg_we   = 1'b1;
        cfg_addr = CHW'(addr);
        cfg_data = 32'(data);
        @(posedge clk);
        #1;
        cfg_we = 1'b0;
    endtask

    task automatic beat(input int acc, input bit clr);
        @(negedge clk);
        in_valid = 1'b1;
        in_data  = 32'(acc);
        ch_clear = clr;
        @(posedge clk);
        #1;
        ch_clear = 1'b0;
    endtask

    task automatic idle();
        @(negedge clk);
        in_valid = 1'b0;
        @(posedge clk);
        #1;
    endtask

    task automatic chk_out(input string nm, input int d, input int ch);
        chk({nm, ".valid"}, longint'(out_valid), 1);
        chk({nm, ".data"}, longint'($signed(out_data)), longint'(d));
        chk({nm, ".ch"}, longint'(out_ch), longint'(ch));
    endtask

    initial begin
        tests     = 0;
        fails     = 0;
        rst_n     = 1'b0;
        cfg_we    = 1'b0;
        cfg_addr  = '0;
        cfg_data  = '0;
        ch_clear  = 1'b0;
        in_valid  = 1'b0;
        in_data   = '0;
        out_ready = 1'b1;

        vecs[0] = '{10,     15,     15,    0, 0, 0, 0};
        vecs[1] = '{10,     5,      5,     1, 0, 0, 0};
        vecs[2] = '{10,     110,    110,   2, 0, 0, 0};
        vecs[3] = '{10,     10,     10,    3, 1, 0, 0};
        vecs[4] = '{32760,  32765,  32765, 0, 0, 0, 0};
        vecs[5] = '{-32800, -32768, 0,     1, 0, 1, 0};
        vecs[6] = '{32760,  32767,  32767, 2, 0, 1, 1};
        vecs[7] = '{-32800, -32768, 0,     3, 1, 1, 0};
        vecs[8] = '{-20,    -15,    0,     0, 0, 0, 0};

        #12;
        chk("rst.valid", longint'(out_valid), 0);
        chk("rst.data", longint'(out_data), 0);
        chk("rst.ch", longint'(out_ch), 0);
        chk("rst.last", longint'(out_last), 0);
        chk("rst.sat", longint'(sat_flag), 0);
        @(negedge clk);
        rst_n = 1'b1;

        write_bias(0, 5);
        write_bias(1, -5);
        write_bias(2, 100);
        write_bias(3, 0);

        for (int i = 0; i < 9; i++) begin
            int ed;
            bit es;
`ifdef BIAS_RELU_EN
            ed = vecs[i].exp_relu;
            es = vecs[i].exp_sat_relu;
`else
            ed = vecs[i].exp_data;
            es = vecs[i].exp_sat;
`endif
            beat(vecs[i].acc, 1'b0);
            chk_out($sformatf("vec%0d", i), ed, vecs[i].exp_ch);
            chk($sformatf("vec%0d.last", i), longint'(out_last),
                longint'(vecs[i].exp_last));
            chk($sformatf("vec%0d.sat", i), longint'(sat_flag), longint'(es));
        end
        idle();
        chk("drain.valid", longint'(out_valid), 0);

        // Counter is at ch1; clear with no beat.
        @(negedge clk);
        ch_clear = 1'b1;
        @(posedge clk);
        #1;
        ch_clear = 1'b0;

        // Backpressure: first beat ch0 (bias 5), second beat held.
        @(negedge clk);
        out_ready = 1'b0;
        in_valid  = 1'b1;
        in_data   = 32'(1);
        @(posedge clk);
        #1;
        chk_out("stall.first", 6, 0);
        in_data = 32'(20);
        for (int c = 0; c < 3; c++) begin
            @(posedge clk);
            #1;
            chk($sformatf("stall%0d.ready", c), longint'(in_ready), 0);
            chk_out($sformatf("stall%0d", c), 6, 0);
        end
        @(negedge clk);
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        chk_out("stall.second", 15, 1);
        idle();
        chk("stall.drain", longint'(out_valid), 0);

        // Same-cycle bias write and accept on ch2.
        write_bias(2, 1);
        @(negedge clk);
        in_valid = 1'b1;
        in_data  = '0;
        cfg_we   = 1'b1;
        cfg_addr = 2'd2;
        cfg_data = 32'(7);
        @(posedge clk);
        #1;
        cfg_we = 1'b0;
        chk_out("coll.old", 1, 2);
        beat(0, 1'b0);
        beat(0, 1'b0);
        chk_out("coll.ch0", 5, 0);
        beat(10, 1'b0);
        beat(0, 1'b0);
        chk_out("coll.new", 7, 2);

        // Advance to ch2 again, then reset mid-pixel.
        beat(0, 1'b0);
        beat(0, 1'b0);
        beat(0, 1'b0);
        beat(0, 1'b0);
        chk_out("pre_rst", 7, 2);
        @(negedge clk);
        in_valid = 1'b0;
        rst_n    = 1'b0;
        #1;
        chk("mrst.valid", longint'(out_valid), 0);
        chk("mrst.data", longint'(out_data), 0);
        @(negedge clk);
        rst_n = 1'b1;
        beat(10, 1'b0);
        chk_out("post_rst", 10, 0);
        beat(10, 1'b1);
        chk_out("clr.beat", 10, 1);
        beat(10, 1'b0);
        chk_out("clr.after", 10, 0);
        idle();

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
